seg7_scan_mux: RTL and testbench

//  Time-multiplexes four 7-segment digits onto one shared segment bus with per-digit anodes.

---
 rtl/seg7_pkg.sv | 27 ++
 rtl/seg7_refresh_timer.sv | 38 +++
 rtl/seg7_scan_mux.sv | 149 ++++++++++++++
 tb/tb_seg7_scan_mux.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants and types for the four-digit 7-segment scan multiplexer.
// Segment patterns are active-low, bit order gfedcba.
package seg7_pkg;

    localparam logic [6:0] SEG_OFF  = 7'h7F;
    localparam logic [6:0] SEG_ZERO = 7'b1000000;
    localparam logic [6:0] SEG_C    = 7'b1000110;

    // Phase of the current digit slot: dead time first, then the digit is lit
    typedef enum logic [0:0] {
        StBlank = 1'b0,
        StDrive = 1'b1
    } scan_state_e;

    typedef logic [1:0] digit_idx_t;

    localparam digit_idx_t DIGIT_UNITS    = 2'd0;
    localparam digit_idx_t DIGIT_TENS     = 2'd1;
    localparam digit_idx_t DIGIT_HUNDREDS = 2'd2;
    localparam digit_idx_t DIGIT_SYM      = 2'd3;

    // Active-low one-hot anode select for a digit index
    function automatic logic [3:0] anode_sel(input digit_idx_t idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/seg7_refresh_timer.sv
// seg7_refresh_timer: slot divider for the digit scan.
// Counts 0..TICK_DIV-1 and wraps; each wrap ends one digit slot.
// Requires 1 <= BLANK_CYCLES < TICK_DIV.
// Ports:
//   clk_in    system clock
//   rst_in    synchronous active-high reset (count returns to 0)
//   slot_end  high on the last count of a slot (count == TICK_DIV-1)
//   in_blank  high when the count loaded at the coming edge lies in the dead-time window
module seg7_refresh_timer #(
    parameter int unsigned TICK_DIV     = 50000,
    parameter int unsigned BLANK_CYCLES = 64
) (
    input  logic clk_in,
    input  logic rst_in,
    output logic slot_end,
    output logic in_blank
);

    localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        slot_end = (cnt_q == CntW'(TICK_DIV - 1));
        cnt_d    = slot_end ? '0 : cnt_q + 1'b1;
        // Looking at the next count lets the caller's state register line up with cnt_q
        in_blank = (32'(cnt_d) < BLANK_CYCLES);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux: time-multiplexes units/tens/hundreds/symbol digits onto one shared
// active-low segment bus with active-low per-digit anodes. Incoming patterns are
// double-buffered and only become visible at a frame boundary, so a frame never tears.
// Optional build macro: SEG_LZ_BLANK_EN enables leading-zero blanking of hundreds/tens.
// Ports:
//   clk_in        system clock
//   rst_in        synchronous active-high reset
//   units_in      units pattern (gfedcba, active-low)
//   tens_in       tens pattern
//   hundreds_in   hundreds pattern
//   load_in       1-cycle strobe capturing the three patterns
//   load_ack_out  1-cycle pulse when captured patterns are promoted to the display
//   seg_out       shared segment bus (gfedcba, active-low)
//   an_out        anodes, active-low; [0]=units .. [3]=symbol
//   frame_out     1-cycle pulse on each slot 3->0 wrap
module seg7_scan_mux
    import seg7_pkg::*;
#(
    parameter int unsigned CLK_HZ       = 50_000_000,
    parameter int unsigned REFRESH_HZ   = 1000,
    parameter int unsigned BLANK_CYCLES = 64,
    parameter logic [6:0]  SYM_PATTERN  = SEG_C
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [6:0] units_in,
    input  logic [6:0] tens_in,
    input  logic [6:0] hundreds_in,
    input  logic       load_in,
    output logic       load_ack_out,
    output logic [6:0] seg_out,
    output logic [3:0] an_out,
    output logic       frame_out
);

    localparam int unsigned TICK_DIV = CLK_HZ / REFRESH_HZ;

    logic slot_end, in_blank;

    seg7_refresh_timer #(
        .TICK_DIV     (TICK_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_timer (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .slot_end (slot_end),
        .in_blank (in_blank)
    );

    scan_state_e state_q, state_d;
    digit_idx_t  idx_q, idx_d;

    // [0]=units, [1]=tens, [2]=hundreds
    logic [2:0][6:0] disp_q, disp_d;
    logic [2:0][6:0] pend_pat_q, pend_pat_d;
    logic            pend_q, pend_d;
    logic            ack_d;
    logic            boundary;
    logic            hund_blank, tens_blank;
    logic [6:0]      digit_pat;
    logic [6:0]      seg_d;
    logic [3:0]      an_d;

    assign boundary = slot_end && (idx_q == DIGIT_SYM);

    // Scan FSM: state_q tracks whether the current count is in dead time or drive time
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            StBlank: if (!in_blank) state_d = StDrive;
            StDrive: if (in_blank)  state_d = StBlank;
        endcase
        if (slot_end) begin
            idx_d = idx_q + 2'd1;
        end
    end

    // Double buffer: pending copy waits for the frame boundary
    always_comb begin
        disp_d     = disp_q;
        pend_pat_d = pend_pat_q;
        pend_d     = pend_q;
        ack_d      = 1'b0;
        if (boundary) begin
            if (load_in) begin
                // Load coinciding with the boundary bypasses the pending stage
                disp_d = {hundreds_in, tens_in, units_in};
                pend_d = 1'b0;
                ack_d  = 1'b1;
            end else if (pend_q) begin
                disp_d = pend_pat_q;
                pend_d = 1'b0;
                ack_d  = 1'b1;
            end
        end else if (load_in) begin
            pend_pat_d = {hundreds_in, tens_in, units_in};
            pend_d     = 1'b1;
        end
    end

    always_comb begin
`ifdef SEG_LZ_BLANK_EN
        hund_blank = (disp_q[2] == SEG_ZERO);
        tens_blank = hund_blank && (disp_q[1] == SEG_ZERO);
`else
        hund_blank = 1'b0;
        tens_blank = 1'b0;
`endif
        case (idx_q)
            DIGIT_UNITS:    digit_pat = disp_q[0];
            DIGIT_TENS:     digit_pat = tens_blank ? SEG_OFF : disp_q[1];
            DIGIT_HUNDREDS: digit_pat = hund_blank ? SEG_OFF : disp_q[2];
            default:        digit_pat = SYM_PATTERN;
        endcase
        if (state_q == StDrive) begin
            an_d  = anode_sel(idx_q);
            seg_d = digit_pat;
        end else begin
            an_d  = 4'b1111;
            seg_d = SEG_OFF;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q      <= StBlank;
            idx_q        <= DIGIT_UNITS;
            disp_q       <= {3{SEG_OFF}};
            pend_pat_q   <= {3{SEG_OFF}};
            pend_q       <= 1'b0;
            an_out       <= 4'b1111;
            seg_out      <= SEG_OFF;
            load_ack_out <= 1'b0;
            frame_out    <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            disp_q       <= disp_d;
            pend_pat_q   <= pend_pat_d;
            pend_q       <= pend_d;
            an_out       <= an_d;
            seg_out      <= seg_d;
            load_ack_out <= ack_d;
            frame_out    <= boundary;
        end
    end

endmodule

// File: tb/tb_seg7_scan_mux.sv
module tb_seg7_scan_mux;

    localparam int unsigned TICK  = 10;
    localparam int unsigned BLANK = 2;
    localparam int unsigned FRAME = 4 * TICK;

    localparam logic [6:0] P_OFF  = 7'h7F;
    localparam logic [6:0] P_ZERO = 7'b1000000;
    localparam logic [6:0] P_SYM  = 7'b1000110;
    localparam logic [6:0] P_3    = 7'b0110000;
    localparam logic [6:0] P_5    = 7'b0010010;
    localparam logic [6:0] P_7    = 7'b1111000;
    localparam logic [6:0] P_8    = 7'b0000000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] units = P_OFF, tens = P_OFF, hundreds = P_OFF;
    logic       load = 1'b0;
    logic       load_ack;
    logic [6:0] seg;
    logic [3:0] an;
    logic       frame;

    seg7_scan_mux #(
        .CLK_HZ       (1000),
        .REFRESH_HZ   (100),
        .BLANK_CYCLES (BLANK)
    ) dut (
        .clk_in       (clk),
        .rst_in       (rst),
        .units_in     (units),
        .tens_in      (tens),
        .hundreds_in  (hundreds),
        .load_in      (load),
        .load_ack_out (load_ack),
        .seg_out      (seg),
        .an_out       (an),
        .frame_out    (frame)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int acks   = 0;

    // Reference model: position in time is just the number of clock edges since reset
    int unsigned edges = 0;
    logic [6:0]  m_disp [3];
    logic [6:0]  m_pend [3];
    bit          m_pend_v = 1'b0;

    function automatic logic [6:0] shown(input int unsigned d);
        bit hz, tz;
        hz = 1'b0;
        tz = 1'b0;
`ifdef SEG_LZ_BLANK_EN
        hz = (m_disp[2] == P_ZERO);
        tz = hz && (m_disp[1] == P_ZERO);
`endif
        case (d)
            0: return m_disp[0];
            1: return tz ? P_OFF : m_disp[1];
            2: return hz ? P_OFF : m_disp[2];
            default: return P_SYM;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h (edge %0d)", tag, obs, exp, edges);
        end
    endtask

    task automatic cycle(input bit ld, input logic [6:0] u, input logic [6:0] t,
                         input logic [6:0] h);
        logic [3:0]  e_an;
        logic [6:0]  e_seg;
        bit          e_ack, e_frame;
        int unsigned p, d;
        load     = ld;
        units    = u;
        tens     = t;
        hundreds = h;
        @(posedge clk);
        e_ack   = 1'b0;
        e_frame = 1'b0;
        e_an    = 4'b1111;
        e_seg   = P_OFF;
        if (rst) begin
            edges    = 0;
            m_pend_v = 1'b0;
            for (int i = 0; i < 3; i++) begin
                m_disp[i] = P_OFF;
                m_pend[i] = P_OFF;
            end
        end else begin
            edges++;
            p = (edges - 1) % TICK;
            d = ((edges - 1) / TICK) % 4;
            if (p >= BLANK) begin
                e_an[d] = 1'b0;
                e_seg   = shown(d);
            end
            e_frame = (edges % FRAME == 0);
            if (e_frame) begin
                if (ld) begin
                    m_disp   = '{u, t, h};
                    m_pend_v = 1'b0;
                    e_ack    = 1'b1;
                end else if (m_pend_v) begin
                    m_disp   = m_pend;
                    m_pend_v = 1'b0;
                    e_ack    = 1'b1;
                end
            end else if (ld) begin
                m_pend   = '{u, t, h};
                m_pend_v = 1'b1;
            end
        end
        #1;
        check("an_out", 32'(an), 32'(e_an));
        check("seg_out", 32'(seg), 32'(e_seg));
        check("frame_out", 32'(frame), 32'(e_frame));
        check("load_ack_out", 32'(load_ack), 32'(e_ack));
        if (load_ack === 1'b1) acks++;
        load = 1'b0;
    endtask

    task automatic idle_until(input int unsigned phase);
        for (int i = 0; i < FRAME && (edges % FRAME) != phase; i++) cycle(0, P_OFF, P_OFF, P_OFF);
    endtask

    initial begin
        int a0;
        // 1: reset held 5 cycles
        rst = 1'b1;
        for (int i = 0; i < 5; i++) cycle(0, P_OFF, P_OFF, P_OFF);
        rst = 1'b0;

        // 2: free run with no load, just over two frames
        for (int i = 0; i < 2 * FRAME + 3; i++) cycle(0, P_OFF, P_OFF, P_OFF);
        check("blank_units_no_load", 32'(m_disp[0]), 32'(P_OFF));

        // 3: load "5" mid slot 1, becomes visible only after the boundary
        idle_until(15);
        cycle(1, P_5, P_ZERO, P_ZERO);
        idle_until(0);
        idle_until(5);
        check("units_after_load", 32'(seg), 32'(P_5));

        // 4: two loads in one frame, only the second is shown, one ack
        idle_until(1);
        a0 = acks;
        cycle(1, P_3, P_8, P_8);
        idle_until(22);
        cycle(1, P_8, P_3, P_3);
        idle_until(0);
        idle_until(5);
        check("one_ack_two_loads", 32'(acks - a0), 32'd1);
        check("units_second_load", 32'(seg), 32'(P_8));

        // 5: load on the boundary edge itself
        idle_until(FRAME - 1);
        a0 = acks;
        cycle(1, P_7, P_5, P_3);
        check("ack_on_boundary_load", 32'(load_ack), 32'd1);
        idle_until(5);
        check("units_boundary_load", 32'(seg), 32'(P_7));

        // 6: leading zeros
        cycle(1, P_7, P_ZERO, P_ZERO);
        idle_until(0);
        idle_until(5);
        check("lz_units", 32'(seg), 32'(P_7));
        idle_until(15);
`ifdef SEG_LZ_BLANK_EN
        check("lz_tens", 32'(seg), 32'(P_OFF));
`else
        check("lz_tens", 32'(seg), 32'(P_ZERO));
`endif
        idle_until(25);
`ifdef SEG_LZ_BLANK_EN
        check("lz_hundreds", 32'(seg), 32'(P_OFF));
`else
        check("lz_hundreds", 32'(seg), 32'(P_ZERO));
`endif
        idle_until(35);
        check("symbol", 32'(seg), 32'(P_SYM));

        // Random loads checked against the model
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 15) == 0), 7'($urandom), 7'($urandom), 7'($urandom));
        end

        // Reset mid-slot with a pending load: pending data is dropped
        idle_until(13);
        cycle(1, P_3, P_3, P_3);
        rst = 1'b1;
        cycle(0, P_OFF, P_OFF, P_OFF);
        cycle(0, P_OFF, P_OFF, P_OFF);
        rst = 1'b0;
        a0 = acks;
        for (int i = 0; i < FRAME + 8; i++) cycle(0, P_OFF, P_OFF, P_OFF);
        check("no_ack_after_reset", 32'(acks - a0), 32'd0);
        check("units_blank_after_reset", 32'(seg), 32'(P_OFF));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
